// File: rtl/channel_arbiter.sv
// Round-robin arbiter sharing one M-bit channel among N requesters, with a valid/ready handshake.
// Optional per-grant transfer limit enabled by defining ARB_HOLD_LIMIT_EN.
module channel_arbiter #(
    parameter int  N    = 5,
    parameter int  M    = 4,
    parameter int  HOLD = 8,
    localparam int SW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        req,
    input  logic [N-1:0][M-1:0] channels,
    input  logic                ready,
    output logic [N-1:0]        grant,
    output logic [SW-1:0]       select,
    output logic [M-1:0]        out,
    output logic                valid
);

    if (N < 1 || N > 128) begin : g_bad_n
        $error("channel_arbiter: N must be in 1..128");
    end
    if (HOLD < 1) begin : g_bad_hold
        $error("channel_arbiter: HOLD must be >= 1");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] select_nxt;
    logic [SW-1:0] ptr, ptr_nxt;
    logic [N-1:0]  others;
    logic          hold_hit;
    logic          release_now;

    // Increment modulo N so ptr/select never reach values >= N.
    function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] idx);
        if (int'(idx) >= N - 1) return '0;
        return idx + 1'b1;
    endfunction

    function automatic logic [SW-1:0] rr_pick(input logic [N-1:0] r, input logic [SW-1:0] start);
        logic [SW-1:0] idx;
        logic [SW-1:0] win;
        logic          found;
        idx   = start;
        win   = start;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && r[idx]) begin
                win   = idx;
                found = 1'b1;
            end
            idx = wrap_inc(idx);
        end
        return win;
    endfunction

    always_comb begin
        others         = req;
        others[select] = 1'b0;
    end

    assign valid       = (state == BUSY) && req[select];
    assign out         = channels[select];
    assign release_now = (state == BUSY) && (!req[select] || (hold_hit && (|others)));

    always_comb begin
        grant = '0;
        if (state == BUSY) grant[select] = 1'b1;
    end

`ifdef ARB_HOLD_LIMIT_EN
    localparam int CW = $clog2(HOLD + 1);

    logic [CW-1:0] hold_cnt, hold_cnt_nxt;

    assign hold_hit = valid && ready && (hold_cnt == CW'(HOLD - 1));

    // Limit reached with nobody else waiting: restart the count and keep the owner.
    always_comb begin
        hold_cnt_nxt = hold_cnt;
        if (state == IDLE || release_now) hold_cnt_nxt = '0;
        else if (valid && ready)          hold_cnt_nxt = hold_hit ? '0 : hold_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hold_cnt <= '0;
        else        hold_cnt <= hold_cnt_nxt;
    end
`else
    logic unused_ready;

    assign hold_hit     = 1'b0;
    assign unused_ready = ready;
`endif

    always_comb begin
        state_nxt  = state;
        select_nxt = select;
        ptr_nxt    = ptr;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt  = BUSY;
                    select_nxt = rr_pick(req, ptr);
                end
            end
            BUSY: begin
                // Hand over directly to the next requester to avoid an idle bubble.
                if (release_now) begin
                    ptr_nxt = wrap_inc(select);
                    if (|others) select_nxt = rr_pick(others, wrap_inc(select));
                    else         state_nxt  = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            select <= '0;
            ptr    <= '0;
        end else begin
            state  <= state_nxt;
            select <= select_nxt;
            ptr    <= ptr_nxt;
        end
    end

endmodule

// File: tb/tb_channel_arbiter.sv
// Bench for channel_arbiter: directed scenarios plus random traffic against an owner/pointer model.
module tb_channel_arbiter;

    localparam int N    = 5;
    localparam int M    = 4;
    localparam int HOLD = 8;
    localparam int SW   = 3;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N-1:0]        req;
    logic [N-1:0][M-1:0] channels;
    logic                ready;
    logic [N-1:0]        grant;
    logic [SW-1:0]       select;
    logic [M-1:0]        out;
    logic                valid;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: owner index (-1 when idle), search pointer, transfers by current owner.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;

    channel_arbiter #(.N(N), .M(M), .HOLD(HOLD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .channels (channels),
        .ready    (ready),
        .grant    (grant),
        .select   (select),
        .out      (out),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_search(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int          o;
        int          p;
        int          c;
        logic        rel;
        logic [N-1:0] oth;
        if (!rst_n) begin
            m_owner <= -1;
            m_ptr   <= 0;
            m_cnt   <= 0;
        end else begin
            o = m_owner;
            p = m_ptr;
            c = m_cnt;
            if (o < 0) begin
                if (req != '0) begin
                    o = rr_search(req, p);
                    c = 0;
                end
            end else begin
                oth    = req;
                oth[o] = 1'b0;
                rel    = !req[o];
`ifdef ARB_HOLD_LIMIT_EN
                if (!rel && ready) begin
                    c++;
                    if (c == HOLD) begin
                        c = 0;
                        if (oth != '0) rel = 1'b1;
                    end
                end
`endif
                if (rel) begin
                    p = (o + 1) % N;
                    if (oth != '0) begin
                        o = rr_search(oth, p);
                        c = 0;
                    end else begin
                        o = -1;
                    end
                end
            end
            m_owner <= o;
            m_ptr   <= p;
            m_cnt   <= c;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("grant", 32'(grant), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
            if (m_owner >= 0) begin
                chk("valid", 32'(valid), 32'(req[m_owner]));
                chk("select", 32'(select), 32'(m_owner));
                chk("out", 32'(out), 32'(channels[m_owner]));
            end else begin
                chk("valid_idle", 32'(valid), 32'd0);
            end
            chk("select_range", 32'(int'(select) < N), 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [N-1:0] tmp;
        int           exp_sel;

        for (int i = 0; i < N; i++) channels[i] = M'(i * 3 + 1);
        req   = '0;
        ready = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_select", 32'(select), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_out", 32'(out), 32'd1);

        // Single requester
        req = 5'b00100;
        tick();
        chk("single_grant", 32'(grant), 32'b00100);
        chk("single_select", 32'(select), 32'd2);
        chk("single_valid", 32'(valid), 32'd1);
        chk("single_out", 32'(out), 32'd7);
        req = '0;
        tick();
        chk("single_drop", 32'(grant), 32'd0);

        // Asynchronous reset while busy
        req = 5'b01000;
        tick();
        chk("busy_before_rst", 32'(grant), 32'b01000);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_grant", 32'(grant), 32'd0);
        chk("async_rst_select", 32'(select), 32'd0);
        chk("async_rst_valid", 32'(valid), 32'd0);
        chk("async_rst_out", 32'(out), 32'd1);
        req = '0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_after_rst", 32'(grant), 32'd0);

        // Round-robin with one-cycle drops, no bubbles
        req = 5'b11111;
        tick();
        chk("rr_first", 32'(grant), 32'b00001);
        for (int k = 1; k <= 5; k++) begin
            tmp = 5'b11111;
            tmp[(k - 1) % N] = 1'b0;
            req = tmp;
            tick();
            chk("rr_next", 32'(grant), 32'd1 << (k % N));
            req = 5'b11111;
            tick();
            chk("rr_hold", 32'(grant), 32'd1 << (k % N));
        end

        // Wrap from owner 4
        req = 5'b10000;
        tick();
        chk("wrap_owner4", 32'(select), 32'd4);
        req = 5'b00011;
        tick();
        chk("wrap_to0", 32'(select), 32'd0);
        req = 5'b00010;
        tick();
        chk("wrap_to1", 32'(select), 32'd1);

        // Stall: ready low keeps everything stable
        ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("stall_grant", 32'(grant), 32'b00010);
            chk("stall_select", 32'(select), 32'd1);
            chk("stall_valid", 32'(valid), 32'd1);
            chk("stall_out", 32'(out), 32'd4);
        end
        ready = 1'b1;

        // Transfer limit with a competing requester
        req = '0;
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        req = 5'b00011;
        for (int t = 1; t <= 12; t++) begin
            tick();
`ifdef ARB_HOLD_LIMIT_EN
            exp_sel = (t <= 8) ? 0 : 1;
`else
            exp_sel = 0;
`endif
            chk("hold_select", 32'(select), 32'(exp_sel));
        end
        req = 5'b00001;
        for (int t = 0; t < 20; t++) begin
            tick();
            chk("sole_owner", 32'(grant), 32'b00001);
        end

        // Random traffic
        req = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            channels = (N * M)'($urandom);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
            end
            ready = ($urandom_range(0, 3) != 0);
            if (cyc % 700 == 350) begin
                #1 rst_n = 1'b0;
                #1;
                chk("rand_rst_grant", 32'(grant), 32'd0);
                chk("rand_rst_select", 32'(select), 32'd0);
                chk("rand_rst_valid", 32'(valid), 32'd0);
                rst_n = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
